// File: rtl/lmem_decode_sched.sv
//==============================================================================
// Module   : lmem_decode_sched
// Function : Phase sequencer for the layered LDPC decoder LLR memory:
//            channel load, per-layer read/write sweeps, early exit, unload.
// Revision : 1.0
//==============================================================================
`default_nettype none

module lmem_decode_sched #(
    parameter int ADDRDEPTH    = 20,
    parameter int ADDRESSWIDTH = 5,
    parameter int LAYERS       = 2,
    parameter int LOADDEPTH    = 16,
    parameter int UNLOADDEPTH  = 17,
    parameter int PIPESTAGES   = 15,
    parameter int UNLOAD_LAT   = 1,
    parameter int MAXITRS      = 10,
    parameter int ITRWIDTH     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    load_valid,
    input  logic                    parity_ok,
    output logic                    load_ready,
    output logic                    loaden,
    output logic                    rd_en,
    output logic [ADDRESSWIDTH-1:0] rd_address,
    output logic                    rd_layer,
    output logic                    wr_en,
    output logic                    wr_layer,
    output logic                    firstprocessing_indicate,
    output logic                    unload_en,
    output logic [ADDRESSWIDTH-1:0] unloadAddress,
    output logic                    hd_valid,
    output logic                    busy,
    output logic                    done,
    output logic [ITRWIDTH-1:0]     itr_used
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD       = 3'd1,
        S_PROC_RD    = 3'd2,
        S_PROC_DRAIN = 3'd3,
        S_ITR_CHK    = 3'd4,
        S_UNLOAD     = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    // One phase counter is shared by every state, so size it for the longest phase
    localparam int c_M1      = (ADDRDEPTH > LOADDEPTH) ? ADDRDEPTH : LOADDEPTH;
    localparam int c_M2      = (c_M1 > UNLOADDEPTH) ? c_M1 : UNLOADDEPTH;
    localparam int c_M3      = (c_M2 > PIPESTAGES) ? c_M2 : PIPESTAGES;
    localparam int c_CNT_MAX = (c_M3 > UNLOAD_LAT) ? c_M3 : UNLOAD_LAT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_LAYER_W = (LAYERS > 1) ? $clog2(LAYERS) : 1;

    localparam logic [c_CNT_W-1:0]   c_LOAD_LAST   = c_CNT_W'(LOADDEPTH - 1);
    localparam logic [c_CNT_W-1:0]   c_RD_LAST     = c_CNT_W'(ADDRDEPTH - 1);
    localparam logic [c_CNT_W-1:0]   c_DRAIN_LAST  = c_CNT_W'(PIPESTAGES - 1);
    localparam logic [c_CNT_W-1:0]   c_UNLOAD_LAST = c_CNT_W'(UNLOADDEPTH - 1);
    localparam logic [c_CNT_W-1:0]   c_LAT_LAST    = c_CNT_W'(UNLOAD_LAT - 1);
    localparam logic [c_LAYER_W-1:0] c_LAYER_LAST  = c_LAYER_W'(LAYERS - 1);
    localparam logic [ITRWIDTH-1:0]  c_ITR_LAST    = ITRWIDTH'(MAXITRS - 1);

    state_t                  r_state, w_state_nxt;
    logic [c_CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [c_LAYER_W-1:0]    r_layer, w_layer_nxt;
    logic [ITRWIDTH-1:0]     r_itr, w_itr_nxt;
    logic [ITRWIDTH-1:0]     r_itr_used, w_itr_used_nxt;
    logic                    w_done_nxt;

    logic                    r_load_ready;
    logic                    r_rd_en;
    logic [ADDRESSWIDTH-1:0] r_rd_address;
    logic                    r_rd_layer;
    logic                    r_fpi;
    logic                    r_unload_en;
    logic [ADDRESSWIDTH-1:0] r_unload_address;
    logic                    r_busy;
    logic                    r_done;

    logic [PIPESTAGES-1:0]   r_wr_pipe, w_wr_pipe_nxt;
    logic [PIPESTAGES-1:0]   r_wl_pipe, w_wl_pipe_nxt;
    logic [UNLOAD_LAT-1:0]   r_hd_pipe, w_hd_pipe_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_layer    <= '0;
            r_itr      <= '0;
            r_itr_used <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_layer    <= w_layer_nxt;
            r_itr      <= w_itr_nxt;
            r_itr_used <= w_itr_used_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_layer_nxt    = r_layer;
        w_itr_nxt      = r_itr;
        w_itr_used_nxt = r_itr_used;
        w_done_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt    = S_LOAD;
                    w_cnt_nxt      = '0;
                    w_layer_nxt    = '0;
                    w_itr_nxt      = '0;
                    w_itr_used_nxt = '0;
                end
            end
            S_LOAD: begin
                if (load_valid) begin
                    if (r_cnt == c_LOAD_LAST) begin
                        w_state_nxt = S_PROC_RD;
                        w_cnt_nxt   = '0;
                        w_layer_nxt = '0;
                        w_itr_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
            end
            S_PROC_RD: begin
                if (r_cnt == c_RD_LAST) begin
                    w_state_nxt = S_PROC_DRAIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            S_PROC_DRAIN: begin
                // Drain lasts exactly the pipeline depth, so the layer's last write
                // issues in the final drain cycle and never overlaps the next read.
                if (r_cnt == c_DRAIN_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_layer != c_LAYER_LAST) begin
                        w_layer_nxt = r_layer + c_LAYER_W'(1);
                        w_state_nxt = S_PROC_RD;
                    end else begin
                        w_state_nxt = S_ITR_CHK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            S_ITR_CHK: begin
                w_cnt_nxt = '0;
                if (parity_ok || (r_itr == c_ITR_LAST)) begin
                    w_state_nxt    = S_UNLOAD;
                    w_itr_used_nxt = r_itr + ITRWIDTH'(1);
                end else begin
                    w_state_nxt = S_PROC_RD;
                    w_itr_nxt   = r_itr + ITRWIDTH'(1);
                    w_layer_nxt = '0;
                end
            end
            S_UNLOAD: begin
                if (r_cnt == c_UNLOAD_LAST) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            S_DONE: begin
                if (r_cnt == c_LAT_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    generate
        if (PIPESTAGES > 1) begin : g_wr_pipe_multi
            assign w_wr_pipe_nxt = {r_wr_pipe[PIPESTAGES-2:0], r_rd_en};
            assign w_wl_pipe_nxt = {r_wl_pipe[PIPESTAGES-2:0], r_rd_layer};
        end else begin : g_wr_pipe_single
            assign w_wr_pipe_nxt = r_rd_en;
            assign w_wl_pipe_nxt = r_rd_layer;
        end
        if (UNLOAD_LAT > 1) begin : g_hd_pipe_multi
            assign w_hd_pipe_nxt = {r_hd_pipe[UNLOAD_LAT-2:0], r_unload_en};
        end else begin : g_hd_pipe_single
            assign w_hd_pipe_nxt = r_unload_en;
        end
    endgenerate

    // Outputs are registered from next-state values so they align with the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_ready     <= 1'b0;
            r_rd_en          <= 1'b0;
            r_rd_address     <= '0;
            r_rd_layer       <= 1'b0;
            r_fpi            <= 1'b0;
            r_unload_en      <= 1'b0;
            r_unload_address <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_wr_pipe        <= '0;
            r_wl_pipe        <= '0;
            r_hd_pipe        <= '0;
        end else begin
            r_load_ready     <= (w_state_nxt == S_LOAD);
            r_rd_en          <= (w_state_nxt == S_PROC_RD);
            r_rd_address     <= (w_state_nxt == S_PROC_RD) ? ADDRESSWIDTH'(w_cnt_nxt) : '0;
            r_rd_layer       <= w_layer_nxt[0];
            r_fpi            <= ((w_state_nxt == S_PROC_RD) | w_wr_pipe_nxt[PIPESTAGES-1])
                                & (w_itr_nxt == '0);
            r_unload_en      <= (w_state_nxt == S_UNLOAD);
            r_unload_address <= (w_state_nxt == S_UNLOAD) ? ADDRESSWIDTH'(w_cnt_nxt) : '0;
            r_busy           <= (w_state_nxt != S_IDLE);
            r_done           <= w_done_nxt;
            r_wr_pipe        <= w_wr_pipe_nxt;
            r_wl_pipe        <= w_wl_pipe_nxt;
            r_hd_pipe        <= w_hd_pipe_nxt;
        end
    end

    assign load_ready               = r_load_ready;
    assign loaden                   = r_load_ready & load_valid;
    assign rd_en                    = r_rd_en;
    assign rd_address               = r_rd_address;
    assign rd_layer                 = r_rd_layer;
    assign wr_en                    = r_wr_pipe[PIPESTAGES-1];
    assign wr_layer                 = r_wl_pipe[PIPESTAGES-1];
    assign firstprocessing_indicate = r_fpi;
    assign unload_en                = r_unload_en;
    assign unloadAddress            = r_unload_address;
    assign hd_valid                 = r_hd_pipe[UNLOAD_LAT-1];
    assign busy                     = r_busy;
    assign done                     = r_done;
    assign itr_used                 = r_itr_used;

endmodule

`default_nettype wire

// File: doc/lmem_decode_sched.md
# lmem_decode_sched

Top-level scheduler for the layered LDPC decoder's bit-node (LLR) memory. It sequences one codeword through four phases:
- channel-LLR load;
- per-layer read/write sweeps across the RCU pipeline, for up to MAXITRS iterations;
- early termination on parity success;
- hard-decision unload.

It drives the Lmem control ports (loaden, rd_en/rd_address/rd_layer, wr_en/wr_layer, firstprocessing_indicate, unload_en/unloadAddress) and never touches LLR data.

## Interface
Parameters:
- ADDRDEPTH, 20, row-group addresses per layer (ceil(Z/P))
- ADDRESSWIDTH, 5, width of rd_address and unloadAddress
- LAYERS, 2, layers per iteration
- LOADDEPTH, 16, load beats per codeword
- UNLOADDEPTH, 17, unload beats (addresses 0..16)
- PIPESTAGES, 15, rd_en-to-wr_en latency (memrd + RCU + memwr)
- UNLOAD_LAT, 1, unload_en to valid hard-decision data, in cycles
- MAXITRS, 10, iteration cap
- ITRWIDTH, 4, iteration counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle request to decode; honoured only in IDLE
- load_valid  in  1  channel beat present on load_data this cycle
- parity_ok  in  1  syndrome check result; sampled in ITR_CHK only
- load_ready  out  1  high in LOAD
- loaden  out  1  load_ready & load_valid
- rd_en  out  1  Lmem read enable
- rd_address  out  ADDRESSWIDTH  Lmem read address
- rd_layer  out  1  layer of the current read sweep
- wr_en  out  1  Lmem write enable
- wr_layer  out  1  layer of the current write sweep
- firstprocessing_indicate  out  1  high for every rd_en/wr_en cycle of iteration 0
- unload_en  out  1  Lmem unload enable
- unloadAddress  out  ADDRESSWIDTH  unload address
- hd_valid  out  1  unload_en delayed UNLOAD_LAT cycles
- busy  out  1  high when state is not IDLE
- done  out  1  one-cycle pulse when the unload finishes
- itr_used  out  ITRWIDTH  iterations executed; updated when entering UNLOAD, held until the next accepted start

## Operation
States: IDLE, LOAD, PROC_RD, PROC_DRAIN, ITR_CHK, UNLOAD, DONE. All outputs are registered.

- IDLE
  - start moves to LOAD and clears the load counter, iteration counter and layer.
  - start in any other state is ignored.
- LOAD
  - Each cycle with load_valid set asserts loaden and increments the load counter.
  - With load_valid low, the FSM stalls indefinitely with loaden low.
  - After beat LOADDEPTH-1 is accepted, go to PROC_RD with layer 0 and iteration 0.
- PROC_RD
  - rd_en high for ADDRDEPTH consecutive cycles.
  - rd_address runs 0..ADDRDEPTH-1; rd_layer holds the current layer.
  - Then go to PROC_DRAIN.
- Write path
  - wr_en and wr_layer are rd_en and rd_layer delayed by exactly PIPESTAGES cycles, using a shift register that is cleared on rst.
- PROC_DRAIN
  - Wait until the last wr_en of the layer has been issued.
  - If layer < LAYERS-1: increment the layer and go to PROC_RD on the next cycle.
  - Otherwise go to ITR_CHK.
  - No read of layer L+1 overlaps a write of layer L.
- ITR_CHK (one cycle)
  - If parity_ok, or iteration == MAXITRS-1: go to UNLOAD and set itr_used = iteration+1.
  - Otherwise increment the iteration, set layer to 0 and go to PROC_RD.
- UNLOAD
  - unload_en high for UNLOADDEPTH cycles; unloadAddress runs 0..UNLOADDEPTH-1.
  - Then go to DONE.
- DONE
  - Wait until the last hd_valid has been issued, then pulse done for one cycle and return to IDLE.

Arithmetic: all counters are unsigned and saturate-free; terminal compares use exact equality.

## Timing
- Reset: every output is 0, the state is IDLE, and the write-delay line is flushed. This applies immediately (asynchronously) when rst is asserted mid-operation. A decode interrupted this way is abandoned.
- start at edge t: load_ready is high from t+1.
- Last load beat accepted at edge t: first rd_en at t+1.
- Per layer, with read sweep starting at cycle s:
  - rd_en covers s..s+ADDRDEPTH-1.
  - wr_en covers s+PIPESTAGES..s+PIPESTAGES+ADDRDEPTH-1.
  - The next layer's rd_en starts at s+PIPESTAGES+ADDRDEPTH. This is 35 cycles per layer and 70 per iteration with defaults.
- ITR_CHK occupies the cycle after the final wr_en of the last layer. The first unload_en or next-iteration rd_en follows one cycle later.
- hd_valid = unload_en delayed UNLOAD_LAT cycles. done is asserted the cycle after the final hd_valid.

## Test plan
- Reset and idle: hold rst high mid-LOAD, then release. Required: all outputs 0, busy 0, and start then restarts cleanly from beat 0.
- Load with gaps: 16 beats with load_valid low every third cycle. Required: exactly 16 loaden pulses; rd_en first appears the cycle after the 16th.
- Single-iteration decode: parity_ok=1 at the first ITR_CHK. Required:
  - rd_address 0..19 with layer 0, then 0..19 with layer 1;
  - wr_en lagging rd_en by 15 cycles;
  - firstprocessing_indicate high throughout;
  - itr_used=1;
  - 17 unload_en beats, addresses 0..16;
  - done pulse.
- Iteration cap: parity_ok=0 always. Required: 10 iterations (700 processing cycles); firstprocessing_indicate high only during iteration 0; itr_used=10.
- Early exit at iteration 4: parity_ok=1 only at the 4th ITR_CHK. Required: itr_used=4; unload starts one cycle after that ITR_CHK.
- start ignored while busy: pulse start during PROC_RD and during UNLOAD. Required: no state or counter disturbance and a single done pulse.
